// File: rtl/tone_sequencer_pkg.sv
// Shared types and constants for the tone sequencer.
package tone_pkg;

  localparam int unsigned NOTE_HALF_W = 15;
  localparam int unsigned NOTE_DUR_W  = 24;

  // Half-period value that marks a rest; duration value that marks end of song.
  localparam int unsigned REST_HALF = 0;
  localparam int unsigned END_DUR   = 0;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PLAY
  } state_t;

  typedef struct packed {
    logic [NOTE_HALF_W-1:0] half;
    logic [NOTE_DUR_W-1:0]  dur;
  } note_t;

endpackage

// File: rtl/tone_sequencer_if.sv
// Control/status bundle between the switch logic and the tone sequencer.
interface tone_sequencer_if #(
  parameter int unsigned AW     = 4,
  parameter int unsigned HALF_W = 15,
  parameter int unsigned DUR_W  = 24
);

  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [HALF_W-1:0] wr_half;
  logic [DUR_W-1:0]  wr_dur;
  logic              start;
  logic              stop;
  logic              loop_en;
  logic              speaker;
  logic              busy;
  logic [AW-1:0]     note_idx;
  logic              done;

  modport master (
    output wr_en, wr_addr, wr_half, wr_dur, start, stop, loop_en,
    input  speaker, busy, note_idx, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_half, wr_dur, start, stop, loop_en,
    output speaker, busy, note_idx, done
  );

endinterface

// File: rtl/tone_sequencer_div.sv
// Half-period divider: toggles out every half+1 clocks; half=0 or clr holds out low.
module tone_div
  import tone_pkg::*;
#(
  parameter int unsigned HALF_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [HALF_W-1:0] half,
  output logic              out
);

  logic [HALF_W-1:0] r_tone_cnt;
  logic              r_out;

  // Count 0..half, toggle and restart at the top; clear restarts low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tone_cnt <= '0;
      r_out      <= 1'b0;
    end else if (clr || (half == HALF_W'(REST_HALF))) begin
      r_tone_cnt <= '0;
      r_out      <= 1'b0;
    end else if (r_tone_cnt == half) begin
      r_tone_cnt <= '0;
      r_out      <= ~r_out;
    end else begin
      r_tone_cnt <= r_tone_cnt + HALF_W'(1);
    end
  end

  assign out = r_out;

endmodule

// File: rtl/tone_sequencer.sv
// Table-driven square-wave note sequencer with rests, end marker and loop mode.
module tone_sequencer
  import tone_pkg::*;
#(
  parameter int unsigned HALF_W = 15,
  parameter int unsigned DUR_W  = 24,
  parameter int unsigned DEPTH  = 16
) (
  input  logic             clk,
  input  logic             rst,
  tone_sequencer_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [HALF_W-1:0] r_tbl_half [DEPTH];
  logic [DUR_W-1:0]  r_tbl_dur  [DEPTH];

  state_t            r_state;
  logic [AW-1:0]     r_note_idx;
  logic [HALF_W-1:0] r_cur_half;
  logic [DUR_W-1:0]  r_cur_dur;
  logic [DUR_W-1:0]  r_dur_cnt;
  logic              r_busy;
  logic              r_done;

  logic [HALF_W-1:0] w_rd_half;
  logic [DUR_W-1:0]  w_rd_dur;
  logic              w_play_last;
  logic              w_div_clr;
  logic              w_speaker;

  // Note table: written every cycle on wr_en; reads in LOAD see the pre-edge contents.
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      r_tbl_half[bus.wr_addr] <= bus.wr_half;
      r_tbl_dur[bus.wr_addr]  <= bus.wr_dur;
    end
  end

  assign w_rd_half   = r_tbl_half[r_note_idx];
  assign w_rd_dur    = r_tbl_dur[r_note_idx];
  assign w_play_last = (r_state == PLAY) && (r_dur_cnt == DUR_W'(r_cur_dur - DUR_W'(1)));
  // Divider runs only inside PLAY; clearing on the exit edge keeps speaker low in LOAD/IDLE.
  assign w_div_clr   = (r_state != PLAY) || w_play_last || bus.stop;

  // Sequencer FSM with registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_note_idx <= '0;
      r_cur_half <= '0;
      r_cur_dur  <= '0;
      r_dur_cnt  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.stop) begin
        r_state    <= IDLE;
        r_note_idx <= '0;
        r_dur_cnt  <= '0;
        r_busy     <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (bus.start) begin
              r_state    <= LOAD;
              r_note_idx <= '0;
              r_busy     <= 1'b1;
            end
          end
          LOAD: begin
            r_cur_half <= w_rd_half;
            r_cur_dur  <= w_rd_dur;
            r_dur_cnt  <= '0;
            if (w_rd_dur != DUR_W'(END_DUR)) begin
              r_state <= PLAY;
            end else if (bus.loop_en && (r_note_idx != '0)) begin
              r_note_idx <= '0;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
          PLAY: begin
            if (w_play_last) begin
              r_dur_cnt <= '0;
              if ((r_note_idx == AW'(DEPTH - 1)) && !bus.loop_en) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_note_idx <= r_note_idx + AW'(1);
                r_state    <= LOAD;
              end
            end else begin
              r_dur_cnt <= r_dur_cnt + DUR_W'(1);
            end
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  tone_div #(
    .HALF_W (HALF_W)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_div_clr),
    .half (r_cur_half),
    .out  (w_speaker)
  );

  assign bus.speaker  = w_speaker;
  assign bus.busy     = r_busy;
  assign bus.note_idx = r_note_idx;
  assign bus.done     = r_done;

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Parametrised square-wave note sequencer. Plays a programmable table of (half-period, duration) entries on one speaker pin.
- Replaces the earlier fixed-pitch, hand-chained tone generators with a single table-driven player.
- Adds rests, an end-of-song marker, loop mode, start/stop control and status outputs.
- Sits between the switch/control logic and the speaker output pin.

Parameters:
- HALF_W, 15, width of the half-period value; tone toggles every half+1 clocks.
- DUR_W, 24, width of the note-duration value in clocks.
- DEPTH, 16, number of note-table entries; must be a power of two, ≥2.
- AW, $clog2(DEPTH), table address width (derived, not overridden).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- wr_en  in  1  table write strobe
- wr_addr  in  AW  table write address
- wr_half  in  HALF_W  half-period for entry; 0 = rest
- wr_dur  in  DUR_W  note length in clocks; 0 = end-of-song marker
- start  in  1  single-cycle pulse: begin playback at entry 0
- stop  in  1  single-cycle pulse: abort playback
- loop_en  in  1  on end marker or table end, restart at entry 0 instead of finishing
- speaker  out  1  square-wave output
- busy  out  1  high while not IDLE
- note_idx  out  AW  index of entry being loaded/played
- done  out  1  one-cycle pulse on normal song completion

Behaviour:
- Reset (async): state=IDLE, speaker=0, busy=0, done=0, note_idx=0, all counters 0. Table contents are not reset.
- Table writes:
  - Accepted every cycle in every state. Write lands at the clock edge.
  - A LOAD of the same address in the same cycle returns the old entry.
- FSM states: IDLE, LOAD, PLAY.
- IDLE:
  - speaker=0.
  - start → LOAD with note_idx=0.
- LOAD (exactly 1 cycle):
  - speaker=0. Latch table[note_idx] into cur_half and cur_dur. Clear the tone and duration counters.
  - If cur_dur≠0 → PLAY.
  - If cur_dur=0 and loop_en=1 and note_idx≠0 → note_idx=0, stay in LOAD.
  - Otherwise (end marker): → IDLE, done=1 for one cycle.
  - Entry 0 with dur=0 is an empty song: done always, even when loop_en=1.
- PLAY lasts exactly cur_dur cycles; dur_cnt counts 0..cur_dur-1.
  - Tone (cur_half≠0): tone_cnt counts 0..cur_half. At tone_cnt==cur_half, clear tone_cnt and toggle speaker.
  - Speaker starts low, so the first rising edge comes cur_half+1 cycles into PLAY. Period = 2·(cur_half+1) clocks.
  - Rest (cur_half=0): speaker held 0.
  - At dur_cnt==cur_dur-1:
    - If note_idx==DEPTH-1 and loop_en=0 → IDLE with done pulse.
    - Otherwise note_idx increments, wrapping to 0, → LOAD.
  - Total note time = 1 + cur_dur clocks.
- stop:
  - In any state, → IDLE on the next edge. speaker=0, note_idx=0, no done pulse.
  - stop and start in the same cycle: stop wins.
- start while busy is ignored.
- loop_en is sampled only at end-of-song decisions.
- Outputs are registered. speaker has no combinational path from any input.
- Counter widths: tone_cnt is HALF_W, dur_cnt is DUR_W. No overflow is possible because compares use equality against latched values.

Decomposition:
- Shared package tone_pkg holds:
  - state enum (IDLE, LOAD, PLAY);
  - REST_HALF=0 and END_DUR=0 constants;
  - note_t struct {half, dur} parametrised via package localparams matching the defaults.
- One sub-module, tone_div: divider with ports clk, rst, clr, half[HALF_W], out. It implements the half-period counter and toggle; half=0 forces out=0.
- Table: plain register array in the top.

Test Plan:
- Reset mid-PLAY: assert rst asynchronously → speaker=0, busy=0, note_idx=0 before the next clk edge. Table still readable afterwards.
- Write entry0={3,20}, entry1={0,5}, entry2={x,0}; start → speaker period 8 clocks for 20 PLAY cycles. Then 1 LOAD + 5 rest cycles low, 1 LOAD, done pulses. busy is high for 1+20+1+5+1=28 cycles.
- Same table with loop_en=1 → after entry 2's LOAD, note_idx returns to 0. Tone resumes with no done pulse; stop then drops busy on the next edge.
- Entry0 dur=0, start with loop_en=1 → one LOAD cycle, then done, no hang.
- All DEPTH entries with dur=2, half=1, loop_en=0 → note_idx runs 0..15. done pulses after 16·3 cycles; busy falls the same edge.
- start and stop in the same cycle from IDLE → stays IDLE. start during PLAY → ignored, note_idx unchanged.
